// File: rtl/node_switch_ctrl.sv
// rtl/node_switch_ctrl.sv - synchronized, optionally debounced node switch inputs with Avalon-MM registers and edge irq
// Build option: NODE_SWITCH_DEBOUNCE_EN enables the per-bit debounce filter.
module node_switch_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_nxt;
  logic [WIDTH-1:0] mask, capture;
  logic [WIDTH-1:0] cap_set, cap_clr;
  logic [WIDTH-1:0] rd_mux;

  // Reads are unconditional, and writedata bits above WIDTH-1 are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{read, writedata[31:WIDTH]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef NODE_SWITCH_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt     [WIDTH];
  logic [CW-1:0] cnt_nxt [WIDTH];

  // A bit is accepted only after disagreeing with stable for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign stable_nxt = sync2;
`endif

  assign cap_set = stable ^ stable_nxt;
  assign cap_clr = (write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge wins over a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable  <= '0;
      capture <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      stable  <= stable_nxt;
      capture <= (capture & ~cap_clr) | cap_set;
      if (write && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
      irq <= |(capture & mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = stable;
      2'd1:    rd_mux = sync2;
      2'd2:    rd_mux = mask;
      default: rd_mux = capture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= {{(32 - WIDTH){1'b0}}, rd_mux};
    end
  end

endmodule

// File: doc/node_switch_ctrl.md
NODE_SWITCH_CTRL -- requirements
Module: node_switch_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of node switch inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: number of clk cycles an input must hold steady before it is accepted (legal 2..2^20).
REQ-003 clk  input  1: single clock; all logic is on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 in_port  input  WIDTH: raw asynchronous node switch levels.
REQ-006 address  input  2: Avalon-MM word address.
REQ-007 read  input  1: Avalon read strobe.
REQ-008 write  input  1: Avalon write strobe.
REQ-009 writedata  input  32: Avalon write data.
REQ-010 readdata  output  32: registered Avalon read data.
REQ-011 irq  output  1: registered level interrupt.

Function
REQ-012 in_port SHALL pass through a 2-FF synchronizer per bit before any other use.
REQ-013 Register map: 0 = stable switch state (RO); 1 = raw synchronized state (RO); 2 = irq mask (RW, WIDTH bits); 3 = edge capture (R, write-1-to-clear).
REQ-014 readdata SHALL update one cycle after the address is sampled, zero-extended to 32 bits, every cycle regardless of read (zero wait states, fixed read latency 1).
REQ-015 Writes to addresses 0 and 1 SHALL be ignored; bits above WIDTH-1 of writedata SHALL be ignored.
REQ-016 Stable-state change on any bit (either direction) SHALL set that bit of edge capture in the cycle the stable state updates.
REQ-017 Write to address 3 SHALL clear each capture bit whose writedata bit is 1; a set event and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-018 irq SHALL equal the registered OR of (edge capture AND mask), asserting one cycle after the capture/mask change that makes it true and deasserting one cycle after it becomes false.
REQ-019 Mask changes SHALL NOT modify edge capture.

Reset
REQ-020 While reset is high at a clk edge: readdata=0, irq=0, mask=0, edge capture=0, all debounce counters=0.
REQ-021 Stable state and synchronizer stages SHALL reset to 0; if inputs are 1 on release, the resulting accepted 0->1 change SHALL set capture normally.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; no capture event SHALL result from the aborted count.

Configuration
REQ-023 Macro NODE_SWITCH_DEBOUNCE_EN selects the debounce filter.
REQ-024 Defined: per-bit counter increments while the synchronized bit differs from its stable bit, clears to 0 when they match; when the counter reaches DEBOUNCE_CYCLES-1 the stable bit takes the synchronized value and the counter clears (acceptance DEBOUNCE_CYCLES cycles after the synchronized change).
REQ-025 Not defined: no counters; stable state SHALL equal the synchronized state delayed by one register (acceptance 1 cycle after synchronization); DEBOUNCE_CYCLES ignored.
REQ-026 Register map, read latency and irq behaviour SHALL be identical in both builds.

Verification (DEBOUNCE_CYCLES=16, WIDTH=8, macro defined unless noted)
REQ-027 Reset, in_port=0x00, read addr 0,2,3 -> readdata 0x0 each, irq=0.
REQ-028 in_port 0x00->0x05 held 40 cycles -> addr 0 reads 0x05 after 2+16 cycles, addr 3 reads 0x05; glitch of 0x80 for 10 cycles -> addr 0 unchanged, capture bit 7 clear.
REQ-029 Mask=0x04, capture=0x05 -> irq=1; write 0x04 to addr 3 -> irq=0 next cycle, addr 3 reads 0x01.
REQ-030 Bit 0 acceptance coincident with write 0x01 to addr 3 -> capture bit 0 remains 1.
REQ-031 Reset pulsed at count 10 of a pending 0x02 change, input held -> no capture before reset; after release capture bit 1 sets 18 cycles later.
REQ-032 Macro undefined: in_port 0x00->0xFF -> addr 0 reads 0xFF 3 cycles after change, capture 0xFF, no debounce delay.
